memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Round-robin arbiter for the coprocessor's single shared memory port. It grants exclusive bus ownership to one of `n_req` requesters: index 0 is the main control unit, indices 1..p are the processing elements. Requesters drive address, data and write-enable only while granted and tri-state otherwise. The arbiter guarantees one-hot grants, a one-cycle dead gap between owners, and a watchdog on hold time.

## Interface
- `n_req`, 5, number of requesters (main CU plus p=4 processors); must be ≥2.
- `n_req_log`, 3, width of owner index; must satisfy `n_req_log` ≥ $clog2(`n_req`).
- `max_hold`, 64, maximum consecutive granted cycles; 0 disables the watchdog.
- `hold_width`, 7, hold-counter width; must satisfy `hold_width` ≥ $clog2(`max_hold`+1).
- `i_Clock`, in, 1, the single clock; all state changes on its rising edge.
- `i_Reset`, in, 1, asynchronous active-low reset.
- `i_Request`, in, n_req, level request per requester; held high for as long as the requester wants the bus.
- `o_Grant`, out, n_req, registered one-hot (or all-zero) grant.
- `o_Owner`, out, n_req_log, index of current or most recent owner.
- `o_Bus_Busy`, out, 1, high while any grant is asserted.
- `o_Timeout`, out, 1, one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: `s_Idle`, `s_Granted`, `s_Handover`.
- `s_Idle`:
  - If any `i_Request` bit is high, select the winner by round-robin.
  - Search order: (`r_Last`+1) mod `n_req`, then upward with wrap-around.
  - Set `o_Grant` to the winner's one-hot, `o_Owner` to the winner, `r_Last` to the winner, clear the hold counter, and go to `s_Granted`.
  - If no request is high, stay in `s_Idle`.
- `s_Granted`:
  - The hold counter increments each cycle and saturates at `max_hold`.
  - If `i_Request[o_Owner]` is low: clear `o_Grant` and go to `s_Handover`.
  - Else, if `max_hold`≠0 and the counter equals `max_hold`-1: clear `o_Grant`, pulse `o_Timeout`, and go to `s_Handover`.
  - Otherwise, hold the grant.
  - Requests from other requesters are ignored while a grant is held; no preemption, including for index 0.
- `s_Handover`:
  - Exactly one cycle with all grants low, so the previous owner's tri-state drivers release.
  - Always go to `s_Idle` next.
- `r_Last` starts at `n_req`-1, so requester 0 wins first after reset.
- A requester that timed out and keeps requesting competes normally. It has lowest priority next round because `r_Last` points at it.
- `o_Owner` holds its value through `s_Handover` and `s_Idle`.
- `o_Bus_Busy` equals the OR of `o_Grant`, registered with it.
- Default/illegal state: go to `s_Idle` with all grants cleared.

## Timing
- Reset (asynchronous, any time, including mid-grant):
  - `o_Grant`=0, `o_Owner`=0, `o_Bus_Busy`=0, `o_Timeout`=0.
  - State `s_Idle`, `r_Last`=`n_req`-1, hold counter=0.
  - Outputs clear immediately on the falling edge of `i_Reset`, not at the next clock.
- Grant latency from idle: a request sampled high at edge k yields `o_Grant` high after edge k. A request rising between edges k-1 and k is therefore granted one clock later.
- Release latency: request sampled low at edge k clears the grant after edge k. `s_Handover` occupies cycle k..k+1, and arbitration happens at edge k+2. The next grant is visible after edge k+2.
- Minimum idle gap between two different owners: 2 cycles with grant low.
- Watchdog: with `max_hold`=M, a continuously requesting owner holds the grant for exactly M cycles. `o_Timeout` is high for the single cycle after the revoking edge, coincident with the first grant-low cycle.
- Simultaneous requests in `s_Idle`: exactly one grant. The winner is the first set bit at or after (`r_Last`+1) mod `n_req`.
- A request dropping and re-rising within `s_Handover` is arbitrated in `s_Idle` like any other.

## Test plan
- Single request:
  - Stimulus: `i_Request`=5'b00100 from reset.
  - Response: `o_Grant`=5'b00100 and `o_Owner`=2 one clock later. After the request drops, grant=0 one clock later, and `o_Bus_Busy` tracks the grant.
- Simultaneous requests after reset:
  - Stimulus: `i_Request`=5'b10011, each requester releasing after 3 cycles and re-requesting.
  - Response: grant order 0, 1, 4, 0, 1, 4, with 2 grant-low cycles between owners.
- Full contention:
  - Stimulus: all 5 requesting, each releasing after 2 cycles held and immediately re-requesting.
  - Response: strict order 0, 1, 2, 3, 4, 0; never two grant bits high.
- Watchdog:
  - Stimulus: `max_hold`=4, requester 3 holds its request forever, requester 1 also requesting.
  - Response: requester 3 is granted exactly 4 cycles; `o_Timeout` pulses 1 cycle; requester 1 is granted 2 cycles later; requester 3 regains the grant after 1 releases.
- Watchdog disabled:
  - Stimulus: `max_hold`=0, requester 0 holds for 200 cycles.
  - Response: grant held for all 200 cycles; `o_Timeout` never asserts.
- Reset mid-grant:
  - Stimulus: assert `i_Reset` low while requester 2 is granted, with requests 2 and 4 still high after release.
  - Response: all outputs 0 asynchronously; after release the first grant goes to requester 2 (lowest index at or after 0 among 2 and 4).

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Shared memory port arbitration bundle.
// Requests flow to the arbiter; grants and status flow back.
interface memory_arbiter_if #(
    parameter int n_req     = 5,
    parameter int n_req_log = 3
);
    logic [n_req-1:0]     i_Request;
    logic [n_req-1:0]     o_Grant;
    logic [n_req_log-1:0] o_Owner;
    logic                 o_Bus_Busy;
    logic                 o_Timeout;

    modport master (
        output i_Request,
        input  o_Grant,
        input  o_Owner,
        input  o_Bus_Busy,
        input  o_Timeout
    );

    modport slave (
        input  i_Request,
        output o_Grant,
        output o_Owner,
        output o_Bus_Busy,
        output o_Timeout
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin owner selection for the single shared memory port,
// with a dead cycle between owners and a hold-time watchdog.
module memory_arbiter #(
    parameter int n_req      = 5,
    parameter int n_req_log  = 3,
    parameter int max_hold   = 64,
    parameter int hold_width = 7
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        s_Idle,
        s_Granted,
        s_Handover
    } state_t;

    localparam logic [n_req_log-1:0] c_Last_Init =
        n_req_log'(n_req - 1);
    localparam logic [n_req-1:0] c_One = n_req'(1);
    localparam bit c_Wd_On = (max_hold != 0);
    localparam logic [hold_width-1:0] c_Hold_Max =
        hold_width'(max_hold);
    localparam logic [hold_width-1:0] c_Hold_Lim =
        c_Wd_On ? hold_width'(max_hold - 1) : '0;

    state_t               r_State;
    logic [n_req-1:0]     r_Grant;
    logic [n_req_log-1:0] r_Owner;
    logic [n_req_log-1:0] r_Last;
    logic [hold_width-1:0] r_Hold;
    logic                 r_Busy;
    logic                 r_Timeout;

    logic [n_req_log-1:0] v_Idx;
    logic [n_req_log-1:0] w_Winner;
    logic                 w_Found;
    logic                 w_Owner_Req;
    logic                 w_Expire;

    // First requester at or after the one following the last owner
    always_comb begin
        w_Found  = 1'b0;
        w_Winner = '0;
        v_Idx    = '0;
        for (int i = 1; i <= n_req; i++) begin
            v_Idx = n_req_log'((int'(r_Last) + i) % n_req);
            if (!w_Found && bus.i_Request[v_Idx]) begin
                w_Found  = 1'b1;
                w_Winner = v_Idx;
            end
        end
    end

    assign w_Owner_Req = bus.i_Request[r_Owner];
    assign w_Expire    = c_Wd_On && (r_Hold == c_Hold_Lim);

    // Ownership FSM; all outputs are registered here
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State   <= s_Idle;
            r_Grant   <= '0;
            r_Owner   <= '0;
            r_Last    <= c_Last_Init;
            r_Hold    <= '0;
            r_Busy    <= 1'b0;
            r_Timeout <= 1'b0;
        end else begin
            r_Timeout <= 1'b0;
            case (r_State)
                s_Idle: begin
                    if (w_Found) begin
                        r_Grant <= c_One << w_Winner;
                        r_Owner <= w_Winner;
                        r_Last  <= w_Winner;
                        r_Hold  <= '0;
                        r_Busy  <= 1'b1;
                        r_State <= s_Granted;
                    end
                end
                s_Granted: begin
                    if (r_Hold != c_Hold_Max) begin
                        r_Hold <= r_Hold + hold_width'(1);
                    end
                    if (!w_Owner_Req) begin
                        r_Grant <= '0;
                        r_Busy  <= 1'b0;
                        r_State <= s_Handover;
                    end else if (w_Expire) begin
                        r_Grant   <= '0;
                        r_Busy    <= 1'b0;
                        r_Timeout <= 1'b1;
                        r_State   <= s_Handover;
                    end
                end
                s_Handover: begin
                    r_State <= s_Idle;
                end
                default: begin
                    r_State <= s_Idle;
                    r_Grant <= '0;
                    r_Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Grant    = r_Grant;
    assign bus.o_Owner    = r_Owner;
    assign bus.o_Bus_Busy = r_Busy;
    assign bus.o_Timeout  = r_Timeout;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: three instances
// (watchdog 64, 4, disabled) share one request stream.
module tb_memory_arbiter;

    typedef struct packed {
        logic [4:0] g;
        logic [2:0] o;
        logic       b;
        logic       t;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] req   = '0;

    always #5 clk = ~clk;

    memory_arbiter_if #(.n_req(5), .n_req_log(3)) bus0 ();
    memory_arbiter_if #(.n_req(5), .n_req_log(3)) bus1 ();
    memory_arbiter_if #(.n_req(5), .n_req_log(3)) bus2 ();

    assign bus0.i_Request = req;
    assign bus1.i_Request = req;
    assign bus2.i_Request = req;

    memory_arbiter #(
        .n_req(5), .n_req_log(3), .max_hold(64), .hold_width(7)
    ) dut0 (.i_Clock(clk), .i_Reset(rst_n), .bus(bus0));

    memory_arbiter #(
        .n_req(5), .n_req_log(3), .max_hold(4), .hold_width(3)
    ) dut1 (.i_Clock(clk), .i_Reset(rst_n), .bus(bus1));

    memory_arbiter #(
        .n_req(5), .n_req_log(3), .max_hold(0), .hold_width(7)
    ) dut2 (.i_Clock(clk), .i_Reset(rst_n), .bus(bus2));

    logic [4:0] a_g [3];
    logic [2:0] a_o [3];
    logic       a_b [3];
    logic       a_t [3];

    assign a_g[0] = bus0.o_Grant;
    assign a_g[1] = bus1.o_Grant;
    assign a_g[2] = bus2.o_Grant;
    assign a_o[0] = bus0.o_Owner;
    assign a_o[1] = bus1.o_Owner;
    assign a_o[2] = bus2.o_Owner;
    assign a_b[0] = bus0.o_Bus_Busy;
    assign a_b[1] = bus1.o_Bus_Busy;
    assign a_b[2] = bus2.o_Bus_Busy;
    assign a_t[0] = bus0.o_Timeout;
    assign a_t[1] = bus1.o_Timeout;
    assign a_t[2] = bus2.o_Timeout;

    int checks = 0;
    int errors = 0;

    int c_M [3] = '{64, 4, 0};
    int m_owner [3];
    int m_last [3];
    int m_held [3];
    int m_gap [3];
    bit m_on [3];
    bit m_to [3];

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    int   seq0 [$];
    int   ep_own [$];
    int   ep_len [$];
    int   to_cnt2 = 0;

    task automatic check(input string name, input int act,
                         input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, expv);
        end
    endtask

    task automatic model_reset(input int k);
        m_owner[k] = 0;
        m_last[k]  = 4;
        m_held[k]  = 0;
        m_gap[k]   = 0;
        m_on[k]    = 1'b0;
        m_to[k]    = 1'b0;
    endtask

    // Behavioural reference: owner, cycles held, dead cycles left
    task automatic model_step(input int k, input logic [4:0] r);
        bit found;
        m_to[k] = 1'b0;
        if (m_on[k]) begin
            m_held[k]++;
            if (!r[m_owner[k]]) begin
                m_on[k]  = 1'b0;
                m_gap[k] = 1;
            end else if (c_M[k] != 0 && m_held[k] == c_M[k]) begin
                m_on[k]  = 1'b0;
                m_to[k]  = 1'b1;
                m_gap[k] = 1;
            end
        end else if (m_gap[k] > 0) begin
            m_gap[k]--;
        end else if (r != 5'b0) begin
            found = 1'b0;
            for (int j = 1; j <= 5; j++) begin
                int c;
                c = (m_last[k] + j) % 5;
                if (!found && r[c]) begin
                    found      = 1'b1;
                    m_owner[k] = c;
                end
            end
            m_last[k] = m_owner[k];
            m_on[k]   = 1'b1;
            m_held[k] = 0;
        end
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.g = m_on[k] ? (5'b00001 << m_owner[k]) : 5'b0;
        e.o = 3'(m_owner[k]);
        e.b = m_on[k];
        e.t = m_to[k];
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) model_reset(k);
            else model_step(k, req);
            push_exp(k);
        end
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async_reset_dut%0d", k),
                  int'({a_g[k], a_o[k], a_b[k], a_t[k]}), 0);
        end
        tick();
        rst_n = 1'b1;
    endtask

    // Requesters release after a random hold and re-request
    task automatic run_phase(input logic [4:0] mask,
                             input int tmin, input int tmax,
                             input int ncyc, input bit idle_rnd);
        int cnt [5];
        int tgt [5];
        int off [5];
        logic [4:0] nxt;
        for (int i = 0; i < 5; i++) begin
            cnt[i] = 0;
            tgt[i] = int'($urandom_range(tmax, tmin));
            off[i] = 0;
        end
        for (int n = 0; n < ncyc; n++) begin
            nxt = '0;
            for (int i = 0; i < 5; i++) begin
                if (mask[i]) begin
                    if (m_on[0] && m_owner[0] == i) begin
                        cnt[i]++;
                        if (cnt[i] >= tgt[i]) begin
                            cnt[i] = 0;
                            tgt[i] = int'($urandom_range(tmax, tmin));
                            off[i] = idle_rnd ?
                                int'($urandom_range(4, 0)) : 0;
                        end else begin
                            nxt[i] = 1'b1;
                        end
                    end else if (off[i] > 0) begin
                        off[i]--;
                    end else begin
                        nxt[i] = 1'b1;
                    end
                end
            end
            req = nxt;
            tick();
        end
    endtask

    // Monitor: pops expectations and checks bus invariants
    initial begin
        logic [4:0] pg [3];
        int   low [3];
        int   len [3];
        bit   seen [3];
        exp_t e;
        bit   have;
        for (int k = 0; k < 3; k++) begin
            pg[k] = '0; low[k] = 0; len[k] = 0; seen[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                have = 1'b0;
                e    = '0;
                case (k)
                    0: if (q0.size() > 0) begin
                        e = q0.pop_front(); have = 1'b1;
                    end
                    1: if (q1.size() > 0) begin
                        e = q1.pop_front(); have = 1'b1;
                    end
                    default: if (q2.size() > 0) begin
                        e = q2.pop_front(); have = 1'b1;
                    end
                endcase
                if (have) begin
                    checks++;
                    if ({a_g[k], a_o[k], a_b[k], a_t[k]} !== e) begin
                        errors++;
                        $display("FAIL outputs_dut%0d t=%0t got g=%b o=%0d b=%b t=%b expected g=%b o=%0d b=%b t=%b",
                                 k, $time, a_g[k], a_o[k], a_b[k],
                                 a_t[k], e.g, e.o, e.b, e.t);
                    end
                end
                checks++;
                if (!$onehot0(a_g[k])) begin
                    errors++;
                    $display("FAIL onehot_dut%0d got %b, expected at most one bit",
                             k, a_g[k]);
                end
                if (k == 2 && a_t[k] === 1'b1) to_cnt2++;
                if (!rst_n) begin
                    pg[k] = '0; low[k] = 0; len[k] = 0;
                    seen[k] = 1'b0;
                end else begin
                    if (a_g[k] != 0 && pg[k] == 0) begin
                        if (seen[k]) begin
                            checks++;
                            if (low[k] < 2) begin
                                errors++;
                                $display("FAIL gap_dut%0d got %0d low cycles, expected >= 2",
                                         k, low[k]);
                            end
                        end
                        seen[k] = 1'b1;
                        len[k]  = 0;
                        if (k == 0) seq0.push_back(int'(a_o[k]));
                    end
                    if (k == 1 && a_g[k] == 0 && pg[k] != 0) begin
                        ep_own.push_back(int'(a_o[k]));
                        ep_len.push_back(len[k]);
                    end
                    if (a_g[k] != 0) begin
                        len[k]++;
                        low[k] = 0;
                    end else begin
                        low[k]++;
                    end
                    pg[k] = a_g[k];
                end
            end
        end
    end

    int exp_a [6];
    int exp_b [6];

    initial begin
        for (int k = 0; k < 3; k++) model_reset(k);
        exp_a = '{0, 1, 4, 0, 1, 4};
        exp_b = '{0, 1, 2, 3, 4, 0};

        do_reset();

        req = 5'b00100;
        tick();
        check("single_grant", int'(a_g[0]), 4);
        check("single_owner", int'(a_o[0]), 2);
        check("single_busy", int'(a_b[0]), 1);
        repeat (3) tick();
        req = 5'b00000;
        tick();
        check("single_release", int'(a_g[0]), 0);
        check("single_busy_low", int'(a_b[0]), 0);
        check("single_owner_hold", int'(a_o[0]), 2);
        repeat (3) tick();

        do_reset();
        seq0.delete();
        run_phase(5'b10011, 3, 3, 40, 1'b0);
        check("order_simul_len", int'(seq0.size() >= 6), 1);
        for (int i = 0; i < 6 && i < seq0.size(); i++)
            check($sformatf("order_simul_%0d", i), seq0[i], exp_a[i]);

        do_reset();
        seq0.delete();
        run_phase(5'b11111, 2, 2, 40, 1'b0);
        check("order_full_len", int'(seq0.size() >= 6), 1);
        for (int i = 0; i < 6 && i < seq0.size(); i++)
            check($sformatf("order_full_%0d", i), seq0[i], exp_b[i]);

        req = 5'b00000;
        do_reset();
        ep_own.delete();
        ep_len.delete();
        req = 5'b01000;
        repeat (2) tick();
        req = 5'b01010;
        repeat (30) tick();
        check("wd_episodes", int'(ep_own.size() >= 3), 1);
        for (int i = 0; i < 3 && i < ep_own.size(); i++) begin
            check($sformatf("wd_owner_%0d", i), ep_own[i],
                  (i == 1) ? 1 : 3);
            check($sformatf("wd_len_%0d", i), ep_len[i], 4);
        end

        req = 5'b00000;
        do_reset();
        req = 5'b00001;
        repeat (200) tick();
        check("wd_off_held", int'(a_g[2]), 1);
        req = 5'b00000;
        repeat (4) tick();

        req = 5'b00100;
        repeat (3) tick();
        req = 5'b10100;
        repeat (2) tick();
        do_reset();
        tick();
        check("post_reset_grant", int'(a_g[0]), 4);
        check("post_reset_owner", int'(a_o[0]), 2);

        run_phase(5'b11111, 1, 10, 1500, 1'b1);
        run_phase(5'b11111, 55, 70, 600, 1'b1);
        req = 5'b00000;
        repeat (10) tick();
        @(negedge clk);
        #1;
        check("wd_off_no_timeout", to_cnt2, 0);
        check("queues_drained",
              q0.size() + q1.size() + q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
